// File: rtl/mux_2_1_arb.sv
// mux_2_1_arb: two-requester round-robin arbiter driving a shared 2:1 mux with bounded hold
module mux_2_1 (
  input  logic [1:0] in,
  input  logic       S,
  output logic       out
);
  assign out = in[S];
endmodule

module mux_2_1_arb #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] in,
  output logic [1:0] gnt,
  output logic       S,
  output logic       out,
  output logic       out_valid
);
  localparam int CW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t state, nxt;
  logic ptr, k, own, oth;
  logic [CW-1:0] hold_cnt;
  // next grant: idle picks sole requester or ptr; owner hands off on release or hold expiry
  always_comb begin
    k = state == G1;
    own = req[k];
    oth = req[~k];
    nxt = state;
    if (state == IDLE) nxt = req == 2'b00 ? IDLE : req == 2'b01 ? G0 : req == 2'b10 ? G1 : (ptr ? G1 : G0);
    else if (!own) nxt = oth ? (k ? G0 : G1) : IDLE;
    else if (oth && hold_cnt == LAST) nxt = k ? G0 : G1;
  end
  // state, hold counter (cleared on each new grant), pointer to the loser, select held while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= 1'b0;
      hold_cnt <= '0;
      S <= 1'b0;
    end else begin
      state <= nxt;
      hold_cnt <= (nxt == IDLE || nxt != state) ? '0 : hold_cnt == LAST ? hold_cnt : hold_cnt + 1'b1;
      if (state != IDLE && nxt != state) ptr <= ~k;
      if (nxt != IDLE) S <= nxt == G1;
    end
  end
  assign gnt = {state == G1, state == G0};
  assign out_valid = |gnt;
  mux_2_1 u_mux (.in(in), .S(S), .out(out));
endmodule
